// File: rtl/ifmux_drr_sched.sv
// Deficit-round-robin grant for the 4 rx ports; optional IFMUX_SCHED_STAT_EN adds per-port grant counters.
// Grant 2 cycles after sched_req when the first visited port qualifies (+1 per extra port); bp aborts a scan to IDLE.
module ifmux_drr_sched #(
  parameter int LEN_W       = 12,
  parameter int DEF_W       = 14,
  parameter int QUANTUM_RST = 1536
) (
  input  logic               clk_sys,
  input  logic               rstn_sys,
  input  logic [3:0]         rx_ptr_fifo_empty,
  input  logic [4*LEN_W-1:0] rx_head_len,
  input  logic               bp,
  input  logic               sched_req,
  input  logic               cfg_load,
  input  logic [4*LEN_W-1:0] cfg_quantum,
  output logic               grant_vld,
  output logic [3:0]         grant_vec,
  output logic [1:0]         grant_bin,
  output logic               sched_busy,
  output logic [63:0]        stat_grant_cnt
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    SCAN  = 4'b0010,
    GRANT = 4'b0100,
    HOLD  = 4'b1000
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic             new_visit, new_visit_nxt;
  logic [DEF_W-1:0] def_q [4];
  logic [LEN_W-1:0] quantum [4];
  logic [LEN_W-1:0] head_len [4];

  logic             any_ready;
  logic [DEF_W:0]   sum;
  logic [DEF_W-1:0] eff;
  logic [DEF_W-1:0] head_ext;
  logic             def_we;
  logic [DEF_W-1:0] def_wdat;
  logic             take;

  always_comb begin
    for (int i = 0; i < 4; i++) head_len[i] = rx_head_len[i*LEN_W +: LEN_W];
  end

  assign any_ready = ~&rx_ptr_fifo_empty;
  assign head_ext  = {{(DEF_W-LEN_W){1'b0}}, head_len[ptr]};
  assign sum       = {1'b0, def_q[ptr]} + {{(DEF_W+1-LEN_W){1'b0}}, quantum[ptr]};
  // The quantum is credited only on arrival at a port, not while it keeps winning.
  assign eff       = !new_visit ? def_q[ptr] : (sum[DEF_W] ? {DEF_W{1'b1}} : sum[DEF_W-1:0]);

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    new_visit_nxt = new_visit;
    def_we        = 1'b0;
    def_wdat      = '0;
    take          = 1'b0;
    case (state)
      IDLE: if (sched_req && !bp && any_ready) state_nxt = SCAN;
      SCAN: begin
        if (bp || !any_ready) begin
          state_nxt = IDLE;
        end else if (rx_ptr_fifo_empty[ptr] || quantum[ptr] == '0) begin
          def_we        = 1'b1;
          ptr_nxt       = ptr + 2'd1;
          new_visit_nxt = 1'b1;
        end else if (eff >= head_ext) begin
          def_we        = 1'b1;
          def_wdat      = eff - head_ext;
          new_visit_nxt = 1'b0;
          take          = 1'b1;
          state_nxt     = GRANT;
        end else begin
          def_we        = 1'b1;
          def_wdat      = eff;
          ptr_nxt       = ptr + 2'd1;
          new_visit_nxt = 1'b1;
        end
      end
      GRANT: state_nxt = HOLD;
      HOLD:  if (!sched_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      new_visit <= 1'b1;
      grant_vec <= 4'd0;
      grant_bin <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        def_q[i]   <= '0;
        quantum[i] <= LEN_W'(QUANTUM_RST);
      end
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      new_visit <= new_visit_nxt;
      if (def_we) def_q[ptr] <= def_wdat;
      if (take) begin
        grant_vec <= 4'b0001 << ptr;
        grant_bin <= ptr;
      end
      if (cfg_load) begin
        for (int i = 0; i < 4; i++) quantum[i] <= cfg_quantum[i*LEN_W +: LEN_W];
      end
    end
  end

  assign grant_vld  = (state == GRANT);
  assign sched_busy = (state != IDLE);

`ifdef IFMUX_SCHED_STAT_EN
  logic [15:0] grant_cnt [4];

  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      for (int i = 0; i < 4; i++) grant_cnt[i] <= 16'd0;
    end else if (take) begin
      grant_cnt[ptr] <= grant_cnt[ptr] + 16'd1;
    end
  end

  assign stat_grant_cnt = {grant_cnt[3], grant_cnt[2], grant_cnt[1], grant_cnt[0]};
`else
  assign stat_grant_cnt = 64'd0;
`endif

endmodule
